fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the pipelined LEGv8 core. It sits directly upstream of the 64-word instruction ROM: it owns the program counter, drives the ROM word address, and latches the returned word into the IF/ID pipeline register. It also handles stall, flush and branch redirect, and detects the end of the program image. Its outputs feed the decode stage.

## Interface
- N, 64: program-counter width in bits.
- ROM_WORDS, 23: number of populated ROM words; word indices at or above this are out of range.
- NOP_WORD, 32'hd503201f: encoding injected as a bubble.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_addr  out  6  ROM word address, equal to pc_F[7:2], combinational.
- imem_q  in  32  ROM read data, combinational from imem_addr.
- stall_D  in  1  hold the PC and IF/ID contents.
- flush_D  in  1  load a bubble into IF/ID.
- branch_taken  in  1  redirect the PC to branch_target.
- branch_target  in  N  redirect byte address; bits [1:0] are ignored (forced 0).
- pc_F  out  N  current fetch PC.
- instr_D  out  32  IF/ID instruction.
- pc_D  out  N  IF/ID PC.
- valid_D  out  1  IF/ID holds a real instruction.
- done  out  1  fetch has halted at the end of the program.
- fetch_count  out  16  count of valid instructions latched into IF/ID; saturates at 16'hFFFF.

## Operation
- in_range = (pc_F[N-1:2] < ROM_WORDS), full-width compare.
- FSM has two states, RUN and HALT. done = (state == HALT).
- Next pc_F, highest priority first:
  - branch_taken: {branch_target[N-1:2], 2'b00}.
  - stall_D: hold.
  - HALT, or RUN with !in_range: hold.
  - otherwise: pc_F + 4. The sum wraps modulo 2^N.
- IF/ID update, highest priority first:
  - branch_taken or flush_D: instr_D = NOP_WORD, valid_D = 0, pc_D = pc_F.
  - stall_D: hold all three.
  - HALT, or !in_range: instr_D = NOP_WORD, valid_D = 0, pc_D = pc_F.
  - otherwise: instr_D = imem_q, valid_D = 1, pc_D = pc_F.
- FSM transitions:
  - RUN → HALT on an edge with !in_range, !stall_D and !branch_taken.
  - HALT → RUN on any edge with branch_taken. If the target is out of range, the FSM re-enters HALT on the following unstalled edge.
  - Flush alone never changes state.
- fetch_count increments on each edge that writes valid_D = 1.
- Simultaneous inputs:
  - branch_taken and stall_D together: the branch wins.
  - flush_D and stall_D together: the flush wins for IF/ID, and the PC holds.

## Timing
- Reset (asynchronous, reset = 0):
  - pc_F = 0, instr_D = NOP_WORD, pc_D = 0, valid_D = 0.
  - fetch_count = 0, state = RUN, done = 0.
- Reset is released synchronously to clk by the environment. The first rising edge after release latches rom[0].
- ROM path is combinational: imem_addr changes in the same cycle as pc_F, and imem_q is sampled at the next edge.
- Latency from PC to IF/ID is one edge. Branch redirect penalty:
  - Edge E (branch_taken = 1): a bubble enters IF/ID and pc_F becomes the target.
  - Edge E+1: IF/ID holds the target instruction.
- Reset asserted mid-run or in HALT: all state returns to reset values immediately, with no clock needed.

## Test plan
- Straight line, no stall/flush/branch:
  - Edge 1: instr_D = 32'h8b1f03e0, pc_D = 0, valid_D = 1.
  - Edge 23: instr_D = 32'hf8000001, pc_D = 0x58.
  - Edge 24: instr_D = NOP_WORD, valid_D = 0, done = 1, pc_F = 0x5C held, fetch_count = 23.
- Stall with pc_F = 0x14: hold stall_D for 3 edges.
  - Required: pc_F stays 0x14 and IF/ID is unchanged.
  - On release, the next edge gives instr_D = 32'h91002001, pc_D = 0x14.
- Flush at pc_F = 0x3C:
  - Required: instr_D = NOP_WORD, valid_D = 0, pc_F = 0x40.
  - Next edge: instr_D = 32'h8b010021.
- Branch, with stall_D = 1 on the same edge: branch_taken = 1, branch_target = 0x2F.
  - Required: pc_F = 0x2C and a bubble in IF/ID.
  - Next edge: instr_D = 32'hb5000102, pc_D = 0x2C.
- Branch out of HALT:
  - branch_taken = 1, target = 0x08: done = 0, then instr_D = 32'hd503201f with valid_D = 1.
  - Branch with target = 0x100: done returns to 1 after one edge.
- Reset mid-run at pc_F = 0x30 with fetch_count = 12: all outputs take reset values asynchronously, before any clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the pipelined LEGv8 core. Owns the program
// counter, drives the word address of the 64-word instruction ROM, and
// latches the returned word into the IF/ID pipeline register. Handles
// decode-side stall, flush and branch redirect, and halts fetch once the PC
// walks past the populated part of the ROM image.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   imem_addr      ROM word address (pc_F[7:2]), combinational
//   imem_q         ROM read data, combinational from imem_addr
//   stall_D        hold PC and IF/ID
//   flush_D        load a bubble into IF/ID
//   branch_taken   redirect PC to branch_target
//   branch_target  redirect byte address, low two bits ignored
//   pc_F           current fetch PC
//   instr_D        IF/ID instruction
//   pc_D           IF/ID PC
//   valid_D        IF/ID holds a real instruction
//   done           fetch has halted at the end of the program
//   fetch_count    valid instructions latched into IF/ID, saturating
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter int          N         = 64,
    parameter int          ROM_WORDS = 23,
    parameter logic [31:0] NOP_WORD  = 32'hd503201f
) (
    input  logic         clk,
    input  logic         reset,
    output logic [5:0]   imem_addr,
    input  logic [31:0]  imem_q,
    input  logic         stall_D,
    input  logic         flush_D,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    output logic [N-1:0] pc_F,
    output logic [31:0]  instr_D,
    output logic [N-1:0] pc_D,
    output logic         valid_D,
    output logic         done,
    output logic [15:0]  fetch_count
);

    // Word-index limit widened to the full PC word-index width so the range
    // compare never truncates high PC bits.
    localparam logic [N-3:0] ROM_LIMIT  = (N-2)'(ROM_WORDS);
    localparam logic [N-1:0] PC_STEP    = N'(4);
    localparam logic [N-1:0] ALIGN_MASK = ~(N'(3));

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         in_range;
    logic         fetch_ok;
    logic [N-1:0] redirect_pc;
    logic [N-1:0] pc_nxt;
    logic         ifid_load;
    logic [31:0]  instr_nxt;
    logic         valid_nxt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign imem_addr   = pc_F[7:2];
    assign in_range    = (pc_F[N-1:2] < ROM_LIMIT);
    assign fetch_ok    = (state == RUN) && in_range;
    // Masking keeps every target bit in the expression while forcing
    // word alignment.
    assign redirect_pc = branch_target & ALIGN_MASK;

    // ---- stage F: next PC ----
    // Branch beats stall; a halted or out-of-range PC simply holds.
    always_comb begin
        pc_nxt = pc_F;
        if (branch_taken) begin
            pc_nxt = redirect_pc;
        end else if (!stall_D && fetch_ok) begin
            pc_nxt = pc_F + PC_STEP;
        end
    end

    // IF/ID write decision. Flush overrides stall for IF/ID only; the PC
    // path above still holds on stall.
    always_comb begin
        ifid_load = 1'b1;
        instr_nxt = NOP_WORD;
        valid_nxt = 1'b0;
        if (branch_taken || flush_D) begin
            ifid_load = 1'b1;
        end else if (stall_D) begin
            ifid_load = 1'b0;
        end else if (fetch_ok) begin
            instr_nxt = imem_q;
            valid_nxt = 1'b1;
        end
    end

    // Halt only when the out-of-range PC is actually being consumed: a
    // stall or a redirect on that edge keeps the FSM running.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (!in_range && !stall_D && !branch_taken) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                if (branch_taken) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // ---- stage F -> D boundary: PC, FSM and IF/ID registers ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_F        <= '0;
            state       <= RUN;
            done        <= 1'b0;
            instr_D     <= NOP_WORD;
            pc_D        <= '0;
            valid_D     <= 1'b0;
            fetch_count <= '0;
        end else begin
            pc_F  <= pc_nxt;
            state <= state_nxt;
            done  <= (state_nxt == HALT);
            if (ifid_load) begin
                instr_D <= instr_nxt;
                pc_D    <= pc_F;
                valid_D <= valid_nxt;
                if (valid_nxt) begin
                    fetch_count <= sat_inc16(fetch_count);
                end
            end
        end
    end

endmodule
